// File: rtl/mdu.sv
//------------------------------------------------------------------------------
// Module   : mdu
// Purpose  : Iterative 32x32 multiply/divide unit with HI/LO result registers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] opnd_q, opnd_d;
    logic        div_q, div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        divz_q, divz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        w_signed, w_sign_a, w_sign_b;
    logic [31:0] w_mag_a, w_mag_b;
    logic [32:0] w_trial, w_sum;
    logic [63:0] w_step, w_prod;
    logic [31:0] w_quo, w_rem;

    // Operand conditioning: signed ops work on magnitudes, signs fixed up at the end.
    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & busA[31];
    assign w_sign_b = w_signed & busB[31];
    assign w_mag_a  = w_sign_a ? (~busA + 32'd1) : busA;
    assign w_mag_b  = w_sign_b ? (~busB + 32'd1) : busB;

    // One iteration: restoring shift-subtract for divide, shift-add for multiply.
    assign w_trial = work_q[63:31] - {1'b0, opnd_q};
    assign w_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign w_step  = div_q ? (w_trial[32] ? {work_q[62:0], 1'b0}
                                          : {w_trial[31:0], work_q[30:0], 1'b1})
                           : {w_sum, work_q[31:1]};

    assign w_prod = neg_res_q ? (~w_step + 64'd1) : w_step;
    assign w_quo  = divz_q ? 32'hFFFF_FFFF
                           : (neg_res_q ? (~w_step[31:0] + 32'd1) : w_step[31:0]);
    assign w_rem  = neg_rem_q ? (~w_step[63:32] + 32'd1) : w_step[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = 5'd0;
                    div_d     = op[1];
                    neg_res_d = w_sign_a ^ w_sign_b;
                    neg_rem_d = w_sign_a;
                    divz_d    = (busB == 32'd0);
                    opnd_d    = op[1] ? w_mag_b : w_mag_a;
                    work_d    = {32'd0, (op[1] ? w_mag_a : w_mag_b)};
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_RUN: begin
                work_d = w_step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    if (div_q) begin
                        hi_d = w_rem;
                        lo_d = w_quo;
                    end else begin
                        hi_d = w_prod[63:32];
                        lo_d = w_prod[31:0];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            work_q    <= 64'd0;
            opnd_q    <= 32'd0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
//------------------------------------------------------------------------------
// Module   : tb_mdu
// Purpose  : Directed self-checking bench for the mdu multiply/divide unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA, busB, wdata;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp;
    int n_err;

    mdu u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .busA  (busA),
        .busB  (busB),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and follow it to completion; operands are scrambled after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output int done_cyc,
                          output logic [31:0] h, output logic [31:0] l);
        int guard;
        @(negedge clk);
        start = 1'b1; op = o; busA = a; busB = b;
        @(negedge clk);
        start = 1'b0; busA = $urandom; busB = $urandom; op = 2'($urandom);
        busy_cyc = 0; done_cyc = 0; guard = 0;
        while (busy && guard < 100) begin
            busy_cyc++;
            if (done) done_cyc++;
            @(negedge clk);
            guard++;
        end
        h = hi; l = lo;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 2'b01; busA = 32'd3; busB = 32'd4;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got=%h want=0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got=%h want=0", lo); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_hold got=%b want=0", busy); end
    endtask

    task automatic test_mul_div();
        logic [1:0]  v_op [12] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10,
                                   2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
        logic [31:0] v_a  [12] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h12345678,
                                   32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000007, 32'h80000000,
                                   32'h00000064, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFFF};
        logic [31:0] v_b  [12] = '{32'hFFFFFFFF, 32'h00000003, 32'h80000000, 32'h00000010,
                                   32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFF,
                                   32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000010};
        logic [31:0] v_hi [12] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h00000001,
                                   32'h00000000, 32'hFFFFFFFF, 32'h00000007, 32'h00000000,
                                   32'h00000002, 32'h00000001, 32'hFFFFFFF9, 32'h0000000F};
        logic [31:0] v_lo [12] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'h23456780,
                                   32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                                   32'h0000000E, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0FFFFFFF};
        int bc, dc;
        logic [31:0] h, l;
        for (int i = 0; i < 12; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], bc, dc, h, l);
            n_cmp++; if (h !== v_hi[i]) begin n_err++; $display("FAIL op%0d_hi got=%h want=%h", i, h, v_hi[i]); end
            n_cmp++; if (l !== v_lo[i]) begin n_err++; $display("FAIL op%0d_lo got=%h want=%h", i, l, v_lo[i]); end
            n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL op%0d_busy_cycles got=%0d want=33", i, bc); end
            n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL op%0d_done_cycles got=%0d want=1", i, dc); end
        end
    endtask

    task automatic test_back_to_back();
        int bc, guard;
        @(negedge clk);
        start = 1'b1; op = 2'b11; busA = 32'd100; busB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        bc = 0; guard = 0;
        while (busy && guard < 100) begin
            bc++;
            start = (bc == 10); lo_we = (bc == 10); hi_we = done;
            op = 2'b01; busA = 32'h5; busB = 32'h5;
            wdata = (bc == 10) ? 32'h0000_1234 : 32'hFFFF_0000;
            @(negedge clk);
            guard++;
        end
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL b2b_busy_cycles got=%0d want=33", bc); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL b2b_hi got=%h want=2", hi); end
        n_cmp++; if (lo !== 32'hE) begin n_err++; $display("FAIL b2b_lo got=%h want=e", lo); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_no_restart got=%b want=0", busy); end
    endtask

    task automatic test_abort();
        int dones, bc, dc;
        logic [31:0] h, l;
        @(negedge clk);
        start = 1'b1; op = 2'b01; busA = 32'hFFFFFFFF; busB = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b want=0", done); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL abort_hi got=%h want=0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL abort_lo got=%h want=0", lo); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        run_op(2'b01, 32'd5, 32'd6, bc, dc, h, l);
        n_cmp++; if (l !== 32'd30) begin n_err++; $display("FAIL abort_rerun_lo got=%h want=1e", l); end
        n_cmp++; if (h !== 32'd0) begin n_err++; $display("FAIL abort_rerun_hi got=%h want=0", h); end
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL abort_rerun_done got=%0d want=1", dc); end
    endtask

    task automatic test_mthi_mtlo();
        int bc, dc;
        logic [31:0] h, l;
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1111_2222;
        @(negedge clk);
        lo_we = 1'b0; hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        n_cmp++; if (hi !== 32'hA5A5A5A5) begin n_err++; $display("FAIL mthi_hi got=%h want=a5a5a5a5", hi); end
        n_cmp++; if (lo !== 32'h11112222) begin n_err++; $display("FAIL mthi_lo_kept got=%h want=11112222", lo); end
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        op = 2'b01; busA = 32'd2; busB = 32'd3;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_cmp++; if (hi !== 32'hA5A5A5A5) begin n_err++; $display("FAIL start_wins_hi got=%h want=a5a5a5a5", hi); end
        n_cmp++; if (lo !== 32'h11112222) begin n_err++; $display("FAIL start_wins_lo got=%h want=11112222", lo); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_wins_busy got=%b want=1", busy); end
        repeat (33) @(negedge clk);
        n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL start_wins_result got=%h want=6", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL start_wins_result_hi got=%h want=0", hi); end
        run_op(2'b00, 32'd1, 32'd1, bc, dc, h, l);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        test_reset();
        test_mul_div();
        test_back_to_back();
        test_abort();
        test_mthi_mtlo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
